// File: rtl/ptw_mem_arbiter.sv
// ptw_mem_arbiter: lets the instruction-side and data-side page table walkers
// share one memory port. Only one request is outstanding at a time. The single
// response goes back to the walker that issued the request. A response timeout
// produces a synthetic fault so a missing response cannot stall a walker.
//
// Ports
//   clk, reset                 clock; asynchronous active-low reset
//   i_req_*  / i_resp_*        instruction PTW request/response (read-only requests)
//   d_req_*  / d_resp_*        data PTW request/response (wen/wdata for A/D updates)
//   mem_req_* / mem_resp_*     shared memory port
//   spurious_resp              sticky flag: a memory response arrived with nothing outstanding
//
// Configuration macro
//   ARB_DATA_PRIORITY_EN       defined: the data PTW always wins a tie
//                              undefined: round-robin between the two walkers
module ptw_mem_arbiter #(
  parameter int unsigned ERRTY_WIDTH    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned TIMEOUT_ERRTY  = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_req_valid,
  output logic                   i_req_ready,
  input  logic [31:0]            i_req_addr,
  output logic                   i_resp_valid,
  output logic [31:0]            i_resp_rdata,
  output logic                   i_resp_error,
  output logic [ERRTY_WIDTH-1:0] i_resp_errty,
  input  logic                   d_req_valid,
  output logic                   d_req_ready,
  input  logic [31:0]            d_req_addr,
  input  logic                   d_req_wen,
  input  logic [31:0]            d_req_wdata,
  output logic                   d_resp_valid,
  output logic [31:0]            d_resp_rdata,
  output logic                   d_resp_error,
  output logic [ERRTY_WIDTH-1:0] d_resp_errty,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [31:0]            mem_req_addr,
  output logic                   mem_req_wen,
  output logic [31:0]            mem_req_wdata,
  input  logic                   mem_resp_valid,
  input  logic [31:0]            mem_resp_rdata,
  input  logic                   mem_resp_error,
  input  logic [ERRTY_WIDTH-1:0] mem_resp_errty,
  output logic                   spurious_resp
);

  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic        OWN_I   = 1'b0;
  localparam logic        OWN_D   = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               owner_q;
  logic [31:0]        addr_q;
  logic               wen_q;
  logic [31:0]        wdata_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               spurious_q;
`ifndef ARB_DATA_PRIORITY_EN
  logic               last_grant_q;
`endif

  logic grant_i, grant_d;
  logic accept;
  logic timeout_hit;
  logic deliver;
  logic [31:0]            resp_rdata;
  logic                   resp_error;
  logic [ERRTY_WIDTH-1:0] resp_errty;

  // Grant decision, only meaningful while IDLE.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
`ifdef ARB_DATA_PRIORITY_EN
    grant_d = d_req_valid;
    grant_i = i_req_valid & ~d_req_valid;
`else
    // On a tie the side that was not granted last time wins.
    grant_i = i_req_valid & (~d_req_valid | (last_grant_q == OWN_D));
    grant_d = d_req_valid & (~i_req_valid | (last_grant_q == OWN_I));
`endif
  end

  assign i_req_ready = (state_q == IDLE) & grant_i;
  assign d_req_ready = (state_q == IDLE) & grant_d;
  assign accept      = i_req_ready | d_req_ready;

  // A real response on the timeout cycle wins over the synthetic fault.
  assign timeout_hit = TO_EN && (cnt_q == CNT_W'(TO_LAST));
  assign deliver     = (state_q == WAIT_RESP) & (mem_resp_valid | timeout_hit);

  // Response payload: memory pass-through, or the synthetic timeout fault.
  always_comb begin
    resp_rdata = 32'd0;
    resp_error = 1'b1;
    resp_errty = ERRTY_WIDTH'(TIMEOUT_ERRTY);
    if (mem_resp_valid) begin
      resp_rdata = mem_resp_rdata;
      resp_error = mem_resp_error;
      resp_errty = mem_resp_errty;
    end
  end

  // Route the response to the owner only; the other side sees zeros.
  always_comb begin
    i_resp_valid = 1'b0;
    i_resp_rdata = 32'd0;
    i_resp_error = 1'b0;
    i_resp_errty = '0;
    d_resp_valid = 1'b0;
    d_resp_rdata = 32'd0;
    d_resp_error = 1'b0;
    d_resp_errty = '0;
    if (deliver) begin
      if (owner_q == OWN_I) begin
        i_resp_valid = 1'b1;
        i_resp_rdata = resp_rdata;
        i_resp_error = resp_error;
        i_resp_errty = resp_errty;
      end else begin
        d_resp_valid = 1'b1;
        d_resp_rdata = resp_rdata;
        d_resp_error = resp_error;
        d_resp_errty = resp_errty;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = ISSUE;
      end
      ISSUE: begin
        if (mem_req_ready) begin
          state_d = WAIT_RESP;
          cnt_d   = '0;
        end
      end
      WAIT_RESP: begin
        if (deliver) state_d = IDLE;
        else         cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched request fields and sticky spurious flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      addr_q       <= 32'd0;
      wen_q        <= 1'b0;
      wdata_q      <= 32'd0;
      cnt_q        <= '0;
      spurious_q   <= 1'b0;
`ifndef ARB_DATA_PRIORITY_EN
      last_grant_q <= OWN_D;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (mem_resp_valid && (state_q != WAIT_RESP)) spurious_q <= 1'b1;
      if (d_req_ready) begin
        owner_q <= OWN_D;
        addr_q  <= d_req_addr;
        wen_q   <= d_req_wen;
        wdata_q <= d_req_wdata;
      end else if (i_req_ready) begin
        // Instruction walks never write.
        owner_q <= OWN_I;
        addr_q  <= i_req_addr;
        wen_q   <= 1'b0;
        wdata_q <= 32'd0;
      end
`ifndef ARB_DATA_PRIORITY_EN
      if (d_req_ready)      last_grant_q <= OWN_D;
      else if (i_req_ready) last_grant_q <= OWN_I;
`endif
    end
  end

  assign mem_req_valid = (state_q == ISSUE);
  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign spurious_resp = spurious_q;

endmodule
